// File: rtl/cardinal_router_local_port.sv
// Local (PE) port terminal of a cardinal router node.
// Drives the NIC link phase, buffers one packet per VC in each direction,
// and exposes valid/grant and write/full interfaces to the crossbar.
module cardinal_router_local_port #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                polarity,
  input  logic                nic_so,
  output logic                nic_ro,
  input  logic [0:DATA_W-1]   nic_do,
  output logic                nic_si,
  input  logic                nic_ri,
  output logic [0:DATA_W-1]   nic_di,
  output logic [1:0]          in_valid,
  output logic [0:DATA_W-1]   in_data0,
  output logic [0:DATA_W-1]   in_data1,
  input  logic [1:0]          in_gnt,
  input  logic [1:0]          out_wr,
  input  logic [0:DATA_W-1]   out_data,
  output logic [1:0]          out_full,
  output logic                proto_err,
  output logic [CNT_W-1:0]    rx_count,
  output logic [CNT_W-1:0]    tx_count
);

  localparam int unsigned NUM_VC = 2;

  logic                ev;
  logic [0:DATA_W-1]   in_buf  [NUM_VC];
  logic [0:DATA_W-1]   out_buf [NUM_VC];

  // The link carries only the VC opposite to the current phase
  assign ev = ~polarity;

  // Ready depends only on registers: the NIC's send request is combinational on it
  assign nic_ro = ~in_valid[ev];

  // Egress handshake and data; data bus is quiet unless a packet is moving
  assign nic_si = out_full[ev] & nic_ri;
  assign nic_di = nic_si ? out_buf[ev] : '0;

  assign in_data0 = in_buf[0];
  assign in_data1 = in_buf[1];

  // Link phase: toggles every cycle out of reset
  always_ff @(posedge clk) begin
    if (reset) polarity <= 1'b0;
    else       polarity <= ~polarity;
  end

  // Ingress buffers: capture on handshake into the phase VC, drain on grant
  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid  <= '0;
      in_buf[0] <= '0;
      in_buf[1] <= '0;
      rx_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      for (int v = 0; v < int'(NUM_VC); v++) begin
        if (in_gnt[v] && in_valid[v]) in_valid[v] <= 1'b0;
      end
      if (nic_so && nic_ro) begin
        in_valid[ev] <= 1'b1;
        in_buf[ev]   <= nic_do;
        rx_count     <= rx_count + CNT_W'(1);
        proto_err    <= (nic_do[0] != ev);
      end
    end
  end

  // Egress buffers: load from crossbar when empty, release when the NIC takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      out_full   <= '0;
      out_buf[0] <= '0;
      out_buf[1] <= '0;
      tx_count   <= '0;
    end else begin
      for (int v = 0; v < int'(NUM_VC); v++) begin
        if (out_wr[v] && !out_full[v]) begin
          out_full[v] <= 1'b1;
          out_buf[v]  <= out_data;
        end
      end
      if (nic_si) begin
        out_full[ev] <= 1'b0;
        tx_count     <= tx_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cardinal_router_local_port.sv
// Bench for cardinal_router_local_port: directed stimulus, queue scoreboard
// for packet data in both directions, direct checks for control/status.
module tb_cardinal_router_local_port;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              polarity;
  logic              nic_so;
  logic              nic_ro;
  logic [0:DATA_W-1] nic_do;
  logic              nic_si;
  logic              nic_ri;
  logic [0:DATA_W-1] nic_di;
  logic [1:0]        in_valid;
  logic [0:DATA_W-1] in_data0;
  logic [0:DATA_W-1] in_data1;
  logic [1:0]        in_gnt;
  logic [1:0]        out_wr;
  logic [0:DATA_W-1] out_data;
  logic [1:0]        out_full;
  logic              proto_err;
  logic [CNT_W-1:0]  rx_count;
  logic [CNT_W-1:0]  tx_count;

  cardinal_router_local_port #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .nic_so(nic_so), .nic_ro(nic_ro), .nic_do(nic_do),
    .nic_si(nic_si), .nic_ri(nic_ri), .nic_di(nic_di),
    .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
    .in_gnt(in_gnt), .out_wr(out_wr), .out_data(out_data),
    .out_full(out_full), .proto_err(proto_err),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [0:DATA_W-1] ing_q0[$];
  logic [0:DATA_W-1] ing_q1[$];
  logic [0:DATA_W-1] eg_q0[$];
  logic [0:DATA_W-1] eg_q1[$];

  logic       pol_m = 1'b0;
  logic       mon_en = 1'b1;
  logic [1:0] prev_valid = 2'b00;

  // Reference phase model
  always @(posedge clk) pol_m <= reset ? 1'b0 : ~pol_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pol(input logic p);
    for (int i = 0; i < 2 && pol_m != p; i++) tick();
  endtask

  // Monitor: pop expected packet whenever the DUT presents one
  always @(negedge clk) begin
    logic [0:DATA_W-1] e;
    if (mon_en) begin
      if (in_valid[0] && !prev_valid[0]) begin
        if (ing_q0.size() == 0) check("ing0_unexpected", 64'd1, 64'd0);
        else begin e = ing_q0.pop_front(); check("ing0_data", in_data0, e); end
      end
      if (in_valid[1] && !prev_valid[1]) begin
        if (ing_q1.size() == 0) check("ing1_unexpected", 64'd1, 64'd0);
        else begin e = ing_q1.pop_front(); check("ing1_data", in_data1, e); end
      end
      if (nic_si) begin
        if (polarity) begin
          if (eg_q0.size() == 0) check("eg0_unexpected", 64'd1, 64'd0);
          else begin e = eg_q0.pop_front(); check("eg0_data", nic_di, e); end
        end else begin
          if (eg_q1.size() == 0) check("eg1_unexpected", 64'd1, 64'd0);
          else begin e = eg_q1.pop_front(); check("eg1_data", nic_di, e); end
        end
      end
    end
    prev_valid = in_valid;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:DATA_W-1] w;
    logic              e;
    reset = 1'b1; nic_so = 0; nic_do = '0; nic_ri = 0;
    in_gnt = 0; out_wr = 0; out_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 4; i++) begin
      check("idle_polarity", polarity, 64'(i % 2));
      check("idle_ro", nic_ro, 1);
      check("idle_si", nic_si, 0);
      check("idle_rx", rx_count, 0);
      check("idle_tx", tx_count, 0);
      check("idle_inv", in_valid, 0);
      check("idle_full", out_full, 0);
      tick();
    end

    // Ingress VC1 at polarity 0
    wait_pol(1'b0);
    nic_so = 1; nic_do = 64'h8000_0000_0000_00AA; ing_q1.push_back(nic_do);
    tick();
    nic_so = 0;
    check("vc1_inv", in_valid, 2'b10);
    check("vc1_data", in_data1, 64'h8000_0000_0000_00AA);
    check("vc1_rx", rx_count, 1);
    check("vc1_perr", proto_err, 0);
    tick();
    check("vc1_ro_blocked", nic_ro, 0);
    in_gnt = 2'b10;
    tick();
    in_gnt = 0;
    check("vc1_drained", in_valid, 0);
    tick();
    check("vc1_ro_again", nic_ro, 1);

    // VC bit mismatch at polarity 1
    wait_pol(1'b1);
    nic_so = 1; nic_do = 64'h8000_0000_0000_0055; ing_q0.push_back(nic_do);
    tick();
    nic_so = 0;
    check("mis_perr", proto_err, 1);
    check("mis_inv", in_valid, 2'b01);
    check("mis_rx", rx_count, 2);
    tick();
    check("mis_perr_pulse", proto_err, 0);
    in_gnt = 2'b01;
    tick();
    in_gnt = 0;
    check("mis_drained", in_valid, 0);

    // Egress backpressure
    nic_ri = 0;
    out_wr = 2'b01; out_data = 64'h0000_0000_0000_1234; eg_q0.push_back(out_data);
    tick();
    out_wr = 0;
    for (int i = 0; i < 6; i++) begin
      check("bp_si", nic_si, 0);
      check("bp_full", out_full, 2'b01);
      if (i == 1) begin out_wr = 2'b01; out_data = 64'h0000_0000_0000_5555; end
      else out_wr = 0;
      tick();
    end
    out_wr = 0;
    check("bp_di_idle", nic_di, 0);
    wait_pol(1'b0);
    nic_ri = 1;
    check("bp_si_wrong_phase", nic_si, 0);
    tick();
    check("bp_si_send", nic_si, 1);
    check("bp_si_polarity", polarity, 1);
    check("bp_di", nic_di, 64'h0000_0000_0000_1234);
    tick();
    check("bp_full_clr", out_full, 0);
    check("bp_tx", tx_count, 1);

    // Both directions, both VCs, 20 packets each
    in_gnt = 2'b11;
    for (int i = 0; i < 20; i++) begin
      e = ~pol_m;
      w = 64'h0000_0000_0000_0A00 + 64'(i);
      w[0] = e;
      nic_so = 1; nic_do = w;
      if (e) ing_q1.push_back(w); else ing_q0.push_back(w);
      out_data = 64'h0000_0000_C000_0000 + 64'(i);
      if (pol_m) begin out_wr = 2'b10; eg_q1.push_back(out_data); end
      else       begin out_wr = 2'b01; eg_q0.push_back(out_data); end
      tick();
      check("cc_perr", proto_err, 0);
    end
    nic_so = 0; out_wr = 0;
    tick();
    in_gnt = 0;
    check("cc_rx", rx_count, 22);
    check("cc_tx", tx_count, 21);
    check("cc_full", out_full, 0);
    check("cc_inv", in_valid, 0);

    // Reset with all four buffers full
    nic_ri = 0;
    wait_pol(1'b0);
    nic_so = 1; nic_do = 64'h8000_0000_0000_0011; ing_q1.push_back(nic_do);
    out_wr = 2'b11; out_data = 64'h0000_0000_0000_DEAD;
    tick();
    nic_do = 64'h0000_0000_0000_0022; ing_q0.push_back(nic_do);
    out_wr = 0;
    tick();
    nic_so = 0;
    check("pre_rst_inv", in_valid, 2'b11);
    check("pre_rst_full", out_full, 2'b11);
    reset = 1;
    tick();
    reset = 0;
    nic_ri = 1;
    check("rst_inv", in_valid, 0);
    check("rst_full", out_full, 0);
    check("rst_pol", polarity, 0);
    check("rst_si", nic_si, 0);
    check("rst_d0", in_data0, 0);
    check("rst_d1", in_data1, 0);
    check("rst_rx", rx_count, 0);
    check("rst_tx", tx_count, 0);
    nic_ri = 0;

    // Counter wrap: one ingress packet per cycle
    mon_en = 0;
    nic_so = 1; nic_do = '0; in_gnt = 2'b11;
    for (int i = 0; i < 65535; i++) tick();
    check("wrap_max", rx_count, 16'hFFFF);
    tick();
    check("wrap_zero", rx_count, 0);
    nic_so = 0; in_gnt = 0;
    tick();

    check("q_ing0_empty", ing_q0.size(), 0);
    check("q_ing1_empty", ing_q1.size(), 0);
    check("q_eg0_empty", eg_q0.size(), 0);
    check("q_eg1_empty", eg_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
